// File: rtl/conv_enc_framer_if.sv
// Source-side handshake and decoder-facing symbol bus of the convolutional encoder framer.
// The master drives source bits and the underrun clear; the slave (the encoder) returns symbols and status.
interface conv_enc_framer_if;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] enc_out;
    logic       enc_valid;
    logic       frame_done;
    logic       underrun;
    logic       clr_underrun;

    modport master (
        output din,
        output din_valid,
        output clr_underrun,
        input  din_ready,
        input  enc_out,
        input  enc_valid,
        input  frame_done,
        input  underrun
    );

    modport slave (
        input  din,
        input  din_valid,
        input  clr_underrun,
        output din_ready,
        output enc_out,
        output enc_valid,
        output frame_done,
        output underrun
    );
endinterface

// File: rtl/conv_enc_framer.sv
// Rate-1/2, K=4 convolutional encoder that frames FRAME_LEN source bits, flushes the trellis
// with three zero tail bits, then idles GAP_LEN cycles so the downstream Viterbi decoder sees enable drop.
//
// state | meaning
// IDLE  | waiting for the first bit of a frame; din_ready high
// DATA  | encoding source bits; a missing din_valid stalls the frame and flags underrun
// TAIL  | encoding the three zero flush bits; last one pulses frame_done
// GAP   | enc_valid low for GAP_LEN cycles before the next frame may start
module conv_enc_framer #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned GAP_LEN   = 2,
    parameter logic [3:0]  G0        = 4'b1111,
    parameter logic [3:0]  G1        = 4'b1101
) (
    input logic              clk,
    input logic              rst,
    conv_enc_framer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [10:0] LAST_BIT  = 11'(FRAME_LEN - 1);
    localparam logic [10:0] LAST_TAIL = 11'd2;
    localparam logic [10:0] LAST_GAP  = 11'(GAP_LEN - 1);

    state_t      state_q, state_d;
    logic [2:0]  sr_q, sr_d;
    logic [10:0] bit_cnt_q, bit_cnt_d;
    logic [10:0] tail_cnt_q, tail_cnt_d;
    logic [10:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]  enc_out_q, enc_out_d;
    logic        enc_valid_q, enc_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic        rdy_en_q;
    logic        din_ready;
    logic        xfer;

    // Symbol is {c0, c1}; bit3 of each generator taps the newest bit.
    function automatic logic [1:0] encode(input logic b, input logic [2:0] sr);
        logic [3:0] reg4;
        reg4 = {b, sr};
        return {^(reg4 & G0), ^(reg4 & G1)};
    endfunction

    // Keeps din_ready low through reset and for the first cycle after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign din_ready      = rdy_en_q && ((state_q == IDLE) || (state_q == DATA));
    assign xfer           = din_ready && bus.din_valid;
    assign bus.din_ready  = din_ready;
    assign bus.enc_out    = enc_out_q;
    assign bus.enc_valid  = enc_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underrun   = underrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sr_q         <= 3'b000;
            bit_cnt_q    <= 11'd0;
            tail_cnt_q   <= 11'd0;
            gap_cnt_q    <= 11'd0;
            enc_out_q    <= 2'b00;
            enc_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            enc_out_q    <= enc_out_d;
            enc_valid_q  <= enc_valid_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        enc_out_d    = enc_out_q;
        enc_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q & ~bus.clr_underrun;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    enc_out_d   = encode(bus.din, sr_q);
                    enc_valid_d = 1'b1;
                    sr_d        = {bus.din, sr_q[2:1]};
                    bit_cnt_d   = 11'd1;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    enc_out_d   = encode(bus.din, sr_q);
                    enc_valid_d = 1'b1;
                    sr_d        = {bus.din, sr_q[2:1]};
                    bit_cnt_d   = bit_cnt_q + 11'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        tail_cnt_d = 11'd0;
                        state_d    = TAIL;
                    end
                end else begin
                    // A stall mid-frame is a source underrun; set wins over a same-cycle clear.
                    underrun_d = 1'b1;
                end
            end
            TAIL: begin
                enc_out_d   = encode(1'b0, sr_q);
                enc_valid_d = 1'b1;
                sr_d        = {1'b0, sr_q[2:1]};
                tail_cnt_d  = tail_cnt_q + 11'd1;
                if (tail_cnt_q == LAST_TAIL) begin
                    frame_done_d = 1'b1;
                    gap_cnt_d    = 11'd0;
                    state_d      = GAP;
                end
            end
            GAP: begin
                enc_out_d = 2'b00;
                gap_cnt_d = gap_cnt_q + 11'd1;
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Bench for conv_enc_framer: a frame-position model computes every output by convolving the
// frame's bit history with the generators; literal frames pin the model against hand-derived symbols.
module tb_conv_enc_framer;

    localparam int FL = 8;
    localparam int GL = 2;
    localparam logic [3:0] G0P = 4'b1111;
    localparam logic [3:0] G1P = 4'b1101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_enc_framer_if bus ();

    conv_enc_framer #(
        .FRAME_LEN(FL),
        .GAP_LEN  (GL),
        .G0       (G0P),
        .G1       (G1P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int clr_pct = 0;
    int n_runs = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pos counts steps into the frame (data 0..FL-1, tail FL..FL+2, gap after).
    int         pos = 0;
    bit         rdy_en = 1'b0;
    bit         hist [FL+3];
    logic [1:0] e_out = 2'b00;
    bit         e_valid = 1'b0;
    bit         e_done = 1'b0;
    bit         e_und = 1'b0;

    function automatic logic [1:0] ref_sym(input int n);
        bit c0, c1;
        logic [3:0] g0, g1;
        g0 = G0P;
        g1 = G1P;
        c0 = 1'b0;
        c1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (n - k >= 0) begin
                c0 = c0 ^ (hist[n-k] & g0[3-k]);
                c1 = c1 ^ (hist[n-k] & g1[3-k]);
            end
        end
        return {c0, c1};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pos = 0; rdy_en = 1'b0; e_out = 2'b00;
                e_valid = 1'b0; e_done = 1'b0; e_und = 1'b0;
            end else begin
                bit ready, taken;
                ready = rdy_en && (pos < FL);
                taken = ready && bus.din_valid;
                e_valid = 1'b0;
                e_done = 1'b0;
                if (rdy_en && pos > 0 && pos < FL && !bus.din_valid) e_und = 1'b1;
                else if (bus.clr_underrun) e_und = 1'b0;
                if (pos < FL) begin
                    if (taken) begin
                        hist[pos] = bus.din;
                        e_out = ref_sym(pos);
                        e_valid = 1'b1;
                        pos++;
                    end
                end else if (pos < FL + 3) begin
                    hist[pos] = 1'b0;
                    e_out = ref_sym(pos);
                    e_valid = 1'b1;
                    e_done = (pos == FL + 2);
                    pos++;
                end else begin
                    e_out = 2'b00;
                    pos++;
                    if (pos == FL + 3 + GL) pos = 0;
                end
                rdy_en = 1'b1;
            end
        end
    end

    logic [1:0] cap_sym [$];
    bit         cap_done [$];

    initial begin
        int lowrun;
        bit counting;
        lowrun = 0;
        counting = 1'b0;
        forever begin
            @(negedge clk);
            chk("din_ready", int'(bus.din_ready), int'(rdy_en && (pos < FL)));
            chk("enc_valid", int'(bus.enc_valid), int'(e_valid));
            chk("enc_out", int'(bus.enc_out), int'(e_out));
            chk("frame_done", int'(bus.frame_done), int'(e_done));
            chk("underrun", int'(bus.underrun), int'(e_und));
            if (rst && pos >= FL + 3) chk("sr_in_gap", int'(dut.sr_q), 0);
            if (!rst) begin
                lowrun = 0;
                counting = 1'b0;
            end else if (!bus.din_ready) begin
                lowrun++;
            end else begin
                if (counting && lowrun > 0) begin
                    chk("ready_low_run", lowrun, 3 + GL);
                    n_runs++;
                end
                lowrun = 0;
                counting = 1'b1;
            end
            if (bus.enc_valid) begin
                cap_sym.push_back(bus.enc_out);
                cap_done.push_back(bus.frame_done);
            end
        end
    end

    task automatic drive(input bit v, input bit d, output bit taken);
        bus.din_valid = v;
        bus.din = d;
        bus.clr_underrun = ($urandom_range(0, 99) < clr_pct);
        @(negedge clk);
        taken = v && bus.din_ready;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        bit t;
        for (int j = 0; j < n; j++) drive(1'b0, 1'b0, t);
    endtask

    task automatic send(input logic [FL-1:0] bits, input int nbits, input int vpct,
                        input int drop_at, input int drop_len);
        int i, dropped, guard;
        bit taken, v;
        i = 0; dropped = 0; guard = 0;
        while (i < nbits) begin
            if (i == drop_at && dropped < drop_len) begin
                drive(1'b0, 1'b0, taken);
                dropped++;
            end else begin
                v = ($urandom_range(0, 99) < vpct);
                drive(v, bits[i], taken);
                if (taken) i++;
            end
            guard++;
            if (guard > 500) begin
                chk("send_timeout", i, nbits);
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [21:0] exp);
        chk({tag, "_len"}, cap_sym.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < cap_sym.size()) begin
                chk({tag, "_sym"}, int'(cap_sym[i]), int'(exp[21-2*i -: 2]));
                chk({tag, "_done"}, int'(cap_done[i]), int'(i == 10));
            end
        end
    endtask

    localparam logic [21:0] IMPULSE  = 22'b11_11_10_11_00_00_00_00_00_00_00;
    localparam logic [21:0] ALL_ONES = 22'b11_00_10_01_01_01_01_01_10_01_11;

    initial begin
        int runs0;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_underrun = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_enc_out", int'(bus.enc_out), 0);
        chk("rst_enc_valid", int'(bus.enc_valid), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_underrun", int'(bus.underrun), 0);
        chk("rst_din_ready", int'(bus.din_ready), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(3);

        cap_sym.delete(); cap_done.delete();
        send(8'b0000_0001, FL, 100, -1, 0);
        idle(8);
        check_frame("impulse", IMPULSE);

        cap_sym.delete(); cap_done.delete();
        send(8'hFF, FL, 100, -1, 0);
        idle(8);
        check_frame("all_ones", ALL_ONES);

        runs0 = n_runs;
        repeat (3) send(8'($urandom), FL, 100, -1, 0);
        idle(8);
        chk("backpressure_runs", n_runs - runs0, 3);

        cap_sym.delete(); cap_done.delete();
        send(8'($urandom), FL, 100, 4, 2);
        idle(8);
        chk("underrun_sticky", int'(bus.underrun), 1);
        chk("underrun_frame_syms", cap_sym.size(), 11);
        clr_pct = 100;
        idle(1);
        clr_pct = 0;
        #1;
        chk("underrun_cleared", int'(bus.underrun), 0);
        idle(2);

        send(8'($urandom), 5, 100, -1, 0);
        rst = 1'b0;
        #1;
        chk("midrst_enc_valid", int'(bus.enc_valid), 0);
        chk("midrst_sr", int'(dut.sr_q), 0);
        chk("midrst_din_ready", int'(bus.din_ready), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(2);
        cap_sym.delete(); cap_done.delete();
        send(8'b0000_0001, FL, 100, -1, 0);
        idle(8);
        check_frame("post_rst_impulse", IMPULSE);

        clr_pct = 5;
        repeat (20) begin
            send(8'($urandom), FL, 75, -1, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        clr_pct = 0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
